// File: rtl/step_ctrl_pkg.sv
// Shared constants for the step controller: FSM state codes and frequency-select range.
package step_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_HALT = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_STEP = 2'd2;

    localparam logic [2:0] FREQ_MAX = 3'd5;

endpackage

// File: rtl/step_ctrl_pb_pulse.sv
// Pushbutton conditioner: DB_LEN-sample debounce, then a one-cycle pulse on the debounced rising edge.
module pb_pulse
    import step_ctrl_pkg::*;
#(
    parameter int DB_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic [DB_LEN-1:0] sh_q;
    logic              level_q;
    logic              level_d;
    logic              pulse_q;

    // Level only moves on a full window of agreeing samples; otherwise it holds.
    always_comb begin
        level_d = level_q;
        if (&sh_q) begin
            level_d = 1'b1;
        end else if (~|sh_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q    <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sh_q    <= {sh_q[DB_LEN-2:0], btn_i};
            level_q <= level_d;
            pulse_q <= level_d & ~level_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/step_ctrl.sv
// Run/halt/single-step controller turning the throttle's slow_clk into a CLK_50 tick enable.
// Define STEP_COUNT_EN to add the step_count port and its wrapping tick counter.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_LEN      = 8
`ifdef STEP_COUNT_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic             CLK_50,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic [2:0]       freq_num,
    input  logic             pb_run,
    input  logic             pb_step,
    input  logic             halt_req,
    output logic             tick,
    output logic             running,
    output logic [2:0]       freq_latched
`ifdef STEP_COUNT_EN
    ,
    output logic [CNT_W-1:0] step_count
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out;
    logic                   slow_edge;
    logic                   run_p;
    logic                   step_p;
    state_t                 state_q;
    state_t                 state_d;
    logic                   tick_q;
    logic                   tick_d;
    logic                   running_q;
    logic [2:0]             freq_q;

    pb_pulse #(.DB_LEN(DB_LEN)) u_run_pb (
        .clk_i   (CLK_50),
        .rst_ni  (reset),
        .btn_i   (pb_run),
        .pulse_o (run_p)
    );

    pb_pulse #(.DB_LEN(DB_LEN)) u_step_pb (
        .clk_i   (CLK_50),
        .rst_ni  (reset),
        .btn_i   (pb_step),
        .pulse_o (step_p)
    );

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign slow_edge = sync_out & ~prev_q;

    // Halt sources are checked before slow_edge so a stop request always suppresses that tick.
    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (run_p) begin
                    state_d = ST_RUN;
                end else if (step_p) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_req || run_p) begin
                    state_d = ST_HALT;
                end else if (slow_edge) begin
                    tick_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (run_p) begin
                    state_d = ST_RUN;
                end else if (slow_edge) begin
                    tick_d  = 1'b1;
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            state_q   <= ST_HALT;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            freq_q    <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            prev_q    <= sync_out;
            state_q   <= state_d;
            tick_q    <= tick_d;
            running_q <= (state_d == ST_RUN);
            if (tick_d) begin
                freq_q <= freq_num;
            end
        end
    end

    assign tick         = tick_q;
    assign running      = running_q;
    assign freq_latched = freq_q;

`ifdef STEP_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (tick_d) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign step_count = cnt_q;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl against a mode-level behavioural model (STEP_COUNT_EN optional).
module tb_step_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int DB_LEN      = 4;
    localparam int CNT_W       = 4;
    // tick is high in the 4th CLK_50 cycle counting the one in which slow_clk rose as the 1st,
    // i.e. visible just after the 3rd rising edge following the change.
    localparam int TICK_LAT    = SYNC_STAGES + 1;

    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic             CLK_50 = 1'b0;
    logic             reset = 1'b0;
    logic             slow_clk = 1'b0;
    logic [2:0]       freq_num = 3'd0;
    logic             pb_run = 1'b0;
    logic             pb_step = 1'b0;
    logic             halt_req = 1'b0;
    logic             tick;
    logic             running;
    logic [2:0]       freq_latched;
`ifdef STEP_COUNT_EN
    logic [CNT_W-1:0] step_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int tick_total = 0;

    int m_mode = M_HALT;
    int m_ticks = 0;
    int m_cnt = 0;
    int m_freq = 0;

    step_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_LEN      (DB_LEN)
`ifdef STEP_COUNT_EN
        ,
        .CNT_W       (CNT_W)
`endif
    ) dut (
        .CLK_50       (CLK_50),
        .reset        (reset),
        .slow_clk     (slow_clk),
        .freq_num     (freq_num),
        .pb_run       (pb_run),
        .pb_step      (pb_step),
        .halt_req     (halt_req),
        .tick         (tick),
        .running      (running),
        .freq_latched (freq_latched)
`ifdef STEP_COUNT_EN
        ,
        .step_count   (step_count)
`endif
    );

    always #5 CLK_50 = ~CLK_50;

    always @(negedge CLK_50) begin
        if (tick === 1'b1) tick_total++;
    end

    // ---------------- reference model (mode level) ----------------
    task automatic mdl_reset();
        m_mode = M_HALT;
        m_cnt  = 0;
        m_freq = 0;
    endtask

    task automatic mdl_press(input bit r, input bit s);
        case (m_mode)
            M_HALT: if (r) m_mode = M_RUN; else if (s) m_mode = M_STEP;
            M_RUN:  if (r) m_mode = M_HALT;
            default: if (r) m_mode = M_RUN;
        endcase
    endtask

    task automatic mdl_halt();
        m_mode = M_HALT;
    endtask

    task automatic mdl_rise(input int f, output bit exp);
        exp = (m_mode != M_HALT);
        if (exp) begin
            m_ticks++;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            m_freq = f;
            if (m_mode == M_STEP) m_mode = M_HALT;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic press(input bit r, input bit s, input int hold);
        pb_run  = r;
        pb_step = s;
        repeat (hold) step();
        pb_run  = 1'b0;
        pb_step = 1'b0;
        repeat (DB_LEN + 4) step();
    endtask

    task automatic pulse_halt();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        step();
        step();
    endtask

    // One slow_clk period: reports first-tick latency (edges after the rise) and total tick cycles.
    task automatic drive_rise(input int f, output int lat, output int width);
        freq_num = 3'(f);
        slow_clk = 1'b1;
        lat   = -1;
        width = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (tick === 1'b1) begin
                if (lat < 0) lat = i;
                width++;
            end
        end
        slow_clk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (tick === 1'b1) width++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int lat, w;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            slow_clk = 1'($urandom);
            pb_run   = 1'($urandom);
            pb_step  = 1'($urandom);
            halt_req = 1'($urandom);
            freq_num = 3'($urandom_range(0, 5));
            step();
            n_cmp++;
            if (tick !== 1'b0 || running !== 1'b0 || freq_latched !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_hold: tick=%b running=%b freq=%0d, want 0/0/0", tick, running, freq_latched);
            end
`ifdef STEP_COUNT_EN
            n_cmp++;
            if (step_count !== '0) begin
                n_bad++;
                $display("FAIL reset_hold_count: step_count=%0d, want 0", step_count);
            end
`endif
        end
        slow_clk = 1'b0; pb_run = 1'b0; pb_step = 1'b0; halt_req = 1'b0;
        step();
        reset = 1'b1;
        mdl_reset();
        step();
        for (int i = 0; i < 10; i++) begin
            drive_rise(int'($urandom_range(0, 5)), lat, w);
            n_cmp++;
            if (w !== 0 || running !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_no_tick: rise %0d tick_cycles=%0d running=%b, want 0/0", i, w, running);
            end
        end
    endtask

    task automatic test_run_tick();
        int lat, w, f;
        bit exp;
        press(1'b1, 1'b0, 6);
        mdl_press(1'b1, 1'b0);
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++;
            $display("FAIL run_press: running=%b, want 1", running);
        end
        for (int i = 0; i < 5; i++) begin
            f = int'($urandom_range(0, 5));
            mdl_rise(f, exp);
            drive_rise(f, lat, w);
            n_cmp++;
            if (w != 1 || lat != TICK_LAT) begin
                n_bad++;
                $display("FAIL run_tick_timing: rise %0d lat=%0d width=%0d, want lat=%0d width=1", i, lat, w, TICK_LAT);
            end
            n_cmp++;
            if (freq_latched !== 3'(m_freq)) begin
                n_bad++;
                $display("FAIL run_freq: freq_latched=%0d, want %0d", freq_latched, m_freq);
            end
        end
`ifdef STEP_COUNT_EN
        n_cmp++;
        if (step_count !== CNT_W'(m_cnt)) begin
            n_bad++;
            $display("FAIL run_count: step_count=%0d, want %0d", step_count, m_cnt);
        end
`endif
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++;
            $display("FAIL run_single_pulse: running=%b, want 1", running);
        end
        press(1'b1, 1'b0, 6);
        mdl_press(1'b1, 1'b0);
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++;
            $display("FAIL run_toggle_halt: running=%b, want 0", running);
        end
    endtask

    task automatic test_single_step();
        int lat, w;
        bit exp;
        press(1'b0, 1'b1, 6);
        mdl_press(1'b0, 1'b1);
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++;
            $display("FAIL step_not_running: running=%b, want 0", running);
        end
        for (int i = 0; i < 3; i++) begin
            mdl_rise(2, exp);
            drive_rise(2, lat, w);
            n_cmp++;
            if (w != (exp ? 1 : 0) || (exp && lat != TICK_LAT)) begin
                n_bad++;
                $display("FAIL single_step: rise %0d lat=%0d width=%0d, want width=%0d", i, lat, w, exp ? 1 : 0);
            end
        end
        pb_step = 1'b1;
        repeat (10) step();
        mdl_press(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            mdl_rise(1, exp);
            drive_rise(1, lat, w);
            n_cmp++;
            if (w != (exp ? 1 : 0)) begin
                n_bad++;
                $display("FAIL held_step: rise %0d width=%0d, want %0d", i, w, exp ? 1 : 0);
            end
        end
        pb_step = 1'b0;
        repeat (DB_LEN + 4) step();
    endtask

    task automatic test_halt_precedence();
        int lat, w;
        press(1'b1, 1'b0, 6);
        mdl_press(1'b1, 1'b0);
        slow_clk = 1'b1;
        step();
        step();
        halt_req = 1'b1;
        step();
        mdl_halt();
        n_cmp++;
        if (tick !== 1'b0 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_in_run: tick=%b running=%b, want 0/0", tick, running);
        end
        halt_req = 1'b0;
        w = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) slow_clk = 1'b0;
            step();
            if (tick === 1'b1) w++;
        end
        n_cmp++;
        if (w != 0) begin
            n_bad++;
            $display("FAIL halt_no_late_tick: tick_cycles=%0d, want 0", w);
        end
        press(1'b0, 1'b1, 6);
        mdl_press(1'b0, 1'b1);
        pulse_halt();
        mdl_halt();
        drive_rise(3, lat, w);
        n_cmp++;
        if (w != 0 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_in_step: tick_cycles=%0d running=%b, want 0/0", w, running);
        end
    endtask

    task automatic test_simul_bounce();
        int lat, w;
        bit exp;
        bit chat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        press(1'b1, 1'b1, 6);
        mdl_press(1'b1, 1'b1);
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_press: running=%b, want 1", running);
        end
        foreach (chat[i]) begin
            pb_run = chat[i];
            step();
        end
        pb_run = 1'b0;
        repeat (DB_LEN + 4) step();
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_ignored: running=%b, want 1", running);
        end
        mdl_rise(0, exp);
        drive_rise(0, lat, w);
        n_cmp++;
        if (w != 1 || lat != TICK_LAT) begin
            n_bad++;
            $display("FAIL post_bounce_tick: lat=%0d width=%0d, want %0d/1", lat, w, TICK_LAT);
        end
    endtask

    task automatic test_latch_wrap();
        int lat, w, guard;
        bit exp;
        if (m_mode != M_RUN) begin
            press(1'b1, 1'b0, 6);
            mdl_press(1'b1, 1'b0);
        end
        mdl_rise(3, exp);
        drive_rise(3, lat, w);
        n_cmp++;
        if (freq_latched !== 3'd3) begin
            n_bad++;
            $display("FAIL latch_3: freq_latched=%0d, want 3", freq_latched);
        end
        freq_num = 3'd5;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (freq_latched !== 3'd3) begin
                n_bad++;
                $display("FAIL latch_hold: cycle %0d freq_latched=%0d, want 3", i, freq_latched);
            end
        end
        mdl_rise(5, exp);
        drive_rise(5, lat, w);
        n_cmp++;
        if (freq_latched !== 3'd5) begin
            n_bad++;
            $display("FAIL latch_5: freq_latched=%0d, want 5", freq_latched);
        end
        guard = 0;
        while ((m_cnt != 0 || m_ticks < 16) && guard < 40) begin
            mdl_rise(int'($urandom_range(0, 5)), exp);
            drive_rise(m_freq, lat, w);
            guard++;
        end
`ifdef STEP_COUNT_EN
        n_cmp++;
        if (step_count !== '0) begin
            n_bad++;
            $display("FAIL count_wrap: step_count=%0d, want 0", step_count);
        end
`endif
        n_cmp++;
        if (tick_total != m_ticks) begin
            n_bad++;
            $display("FAIL tick_total: seen=%0d, want %0d", tick_total, m_ticks);
        end
    endtask

    task automatic test_random();
        int lat, w, f, act;
        bit exp;
        for (int i = 0; i < 40; i++) begin
            act = int'($urandom_range(0, 4));
            case (act)
                0, 1: begin
                    f = int'($urandom_range(0, 5));
                    mdl_rise(f, exp);
                    drive_rise(f, lat, w);
                    n_cmp++;
                    if (w != (exp ? 1 : 0) || (exp && lat != TICK_LAT) || freq_latched !== 3'(m_freq)) begin
                        n_bad++;
                        $display("FAIL rand_rise: iter %0d lat=%0d width=%0d freq=%0d, want width=%0d freq=%0d",
                                 i, lat, w, freq_latched, exp ? 1 : 0, m_freq);
                    end
                end
                2: begin
                    press(1'b1, 1'($urandom), 6);
                    mdl_press(1'b1, 1'b0);
                end
                3: begin
                    press(1'b0, 1'b1, 6);
                    mdl_press(1'b0, 1'b1);
                end
                default: begin
                    pulse_halt();
                    mdl_halt();
                end
            endcase
            n_cmp++;
            if (running !== (m_mode == M_RUN)) begin
                n_bad++;
                $display("FAIL rand_running: iter %0d act %0d running=%b, want %0d", i, act, running, m_mode == M_RUN);
            end
        end
`ifdef STEP_COUNT_EN
        n_cmp++;
        if (step_count !== CNT_W'(m_cnt)) begin
            n_bad++;
            $display("FAIL rand_count: step_count=%0d, want %0d", step_count, m_cnt);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        int lat, w;
        bit exp;
        if (m_mode != M_RUN) begin
            press(1'b1, 1'b0, 6);
            mdl_press(1'b1, 1'b0);
        end
        mdl_rise(4, exp);
        drive_rise(4, lat, w);
        slow_clk = 1'b1;
        step();
        #3;
        reset = 1'b0;
        mdl_reset();
        #1;
        n_cmp++;
        if (tick !== 1'b0 || running !== 1'b0 || freq_latched !== 3'd0) begin
            n_bad++;
            $display("FAIL async_reset: tick=%b running=%b freq=%0d, want 0/0/0", tick, running, freq_latched);
        end
`ifdef STEP_COUNT_EN
        n_cmp++;
        if (step_count !== '0) begin
            n_bad++;
            $display("FAIL async_reset_count: step_count=%0d, want 0", step_count);
        end
`endif
        step();
        slow_clk = 1'b0;
        step();
        reset = 1'b1;
        step();
        mdl_rise(2, exp);
        drive_rise(2, lat, w);
        n_cmp++;
        if (w != (exp ? 1 : 0) || running !== 1'b0 || freq_latched !== 3'(m_freq)) begin
            n_bad++;
            $display("FAIL after_reset: tick_cycles=%0d running=%b freq=%0d, want 0/0/%0d", w, running, freq_latched, m_freq);
        end
    endtask

    initial begin
        test_reset();
        test_run_tick();
        test_single_step();
        test_halt_precedence();
        test_simul_bounce();
        test_latch_wrap();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
